mat_mul_sched: RTL and testbench
================================

# mat_mul_sched

Shared 2x2 matrix-multiply scheduler. It arbitrates between two requesters and accepts one operand pair at a time, buffering the pair internally. It computes the product with a single time-multiplexed multiply-accumulate over 8 cycles, then returns the packed result to the winning requester through a valid/ready handshake. It sits between client blocks and the matrix arithmetic, replacing a fully combinational multiplier where area matters more than latency.

## Interface
- DW, 8, element width; matrices are packed 4*DW bits, MSB first, in order [0][0],[0][1],[1][0],[1][1]
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  requester N presents an operand pair
- req0_a / req1_a  in  4*DW  matrix A of requester N
- req0_b / req1_b  in  4*DW  matrix B of requester N
- req0_ready / req1_ready  out  1  pair accepted this cycle when valid && ready
- rsp0_valid / rsp1_valid  out  1  result for requester N available
- rsp0_r / rsp1_r  out  4*DW  packed result matrix R = A*B
- rsp0_ready / rsp1_ready  in  1  requester N takes the result when valid && ready
- busy  out  1  high in CALC and RESP

## Operation
- States: IDLE, CALC, RESP.
- IDLE: arbitrate. If one valid, grant it. If both valid, grant the one not served last (round-robin). last_grant resets to 1, so req0 wins the first tie.
- reqN_ready is combinational: (state==IDLE) && grant==N. At most one ready is high per cycle, and never both. No ready outside IDLE.
- On accept, latch A and B into internal 2x2 registers, clear R and the accumulator, set owner = N, update last_grant = N, and go to CALC.
- CALC: 3-bit counter step = {i,j,k} runs 0..7. Each cycle: acc_next = (k==0 ? 0 : acc) + A[i][k]*B[k][j].
- At k==1, write R[i][j] = acc_next.
- After step 7, go to RESP.
- Arithmetic: the product is truncated to DW bits, and the sum is modulo 2^DW, matching the combinational datapath. Example: 255*255 + 255*255 gives 2.
- RESP: rsp{owner}_valid is high and rsp{owner}_r = packed R. Both are held stable until rsp{owner}_ready, then the block returns to IDLE.
- A new request is never accepted in the same cycle as a response handshake.
- The non-owner rsp_valid stays 0 and its rsp_r holds 0.
- Requests arriving during CALC/RESP wait. A requester may change or drop its operands while not ready; only the accept-cycle values are used.
- Reset, including mid-CALC or mid-RESP: the operation is aborted and no response is issued. State returns to IDLE, with counter, acc, R, A, B, and owner cleared, and last_grant = 1.

## Timing
- Reset values: all reqN_ready 0 while rst_n low, then follow IDLE logic. rspN_valid 0, rspN_r 0, busy 0.
- Accept at edge T (valid && ready sampled). CALC occupies cycles T+1..T+8, and rsp_valid rises after edge T+8, i.e. visible in cycle T+9.
- If rsp_ready is already high, the handshake completes at edge T+9. IDLE is in cycle T+10, and the next accept is at the earliest edge T+10. Minimum period is 10 cycles per operation.
- Backpressure: each cycle rsp_ready stays low extends RESP by one cycle. Outputs must not change during that time.
- busy is high from cycle T+1 through the response handshake cycle.
- Simultaneous valid on both requesters in IDLE: exactly one handshake occurs, per round-robin. The loser is granted in the next IDLE if it is still valid.

## Test plan
- Reset, then req0 A=0x01000001 (identity), B=0x01020304 -> rsp0_valid in cycle T+9 with rsp0_r=0x01020304; rsp1_valid stays 0; busy 0 after handshake.
- req1 A=0x01020304, B=0x05060708 -> rsp1_r=0x13162B32 ([19,22;43,50]).
- Overflow: A=B=0xFFFFFFFF -> R=0x02020202. Also check A=0x10101010, B=0x10101010 -> R=0x00000000.
- Both valid every cycle with distinct operands -> grants alternate req0, req1, req0, ...; each response returns to the correct port with the correct value; accepts are spaced 10 cycles apart.
- rsp_ready held low for 5 cycles in RESP -> rsp_valid and rsp_r stable for the whole period; no req_ready goes high; completion follows the first ready cycle.
- Assert rst_n low at step 4 of CALC and release it -> no rsp_valid; all outputs are 0 during reset; a following request computes correctly, and req0 wins the first tie.

Source files
------------

// File: rtl/mat_mul_sched.sv
// Shared 2x2 matrix-multiply scheduler: round-robin accept of one operand pair,
// 8-cycle time-multiplexed MAC, then valid/ready return to the winning requester.
module mat_mul_sched #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [4*DW-1:0] req0_a,
  input  logic [4*DW-1:0] req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [4*DW-1:0] req1_a,
  input  logic [4*DW-1:0] req1_b,
  output logic            req1_ready,
  output logic            rsp0_valid,
  output logic [4*DW-1:0] rsp0_r,
  input  logic            rsp0_ready,
  output logic            rsp1_valid,
  output logic [4*DW-1:0] rsp1_r,
  input  logic            rsp1_ready,
  output logic            busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; ready never depends on anything but state and the valid inputs, and a
  // response holds valid/data stable until its ready is seen.
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      step_q, step_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [4*DW-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic            owner_q, owner_d;
  logic            last_q, last_d;

  logic            grant;
  logic            accept;
  logic            rsp_hs;
  logic [1:0]      a_idx, b_idx, r_idx;
  logic [DW-1:0]   prod;
  logic [DW-1:0]   acc_next;

  // Element idx = 2*row + col; element 0 sits in the top DW bits.
  function automatic logic [DW-1:0] elem(input logic [4*DW-1:0] m, input logic [1:0] idx);
    return m[(3 - int'(idx))*DW +: DW];
  endfunction

  assign grant      = (req0_valid && req1_valid) ? ~last_q : req1_valid;
  assign req0_ready = rst_n && (state_q == IDLE) && req0_valid && !grant;
  assign req1_ready = rst_n && (state_q == IDLE) && req1_valid && grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // step = {i,j,k}: A[i][k] * B[k][j] accumulates into R[i][j].
  assign a_idx    = {step_q[2], step_q[0]};
  assign b_idx    = {step_q[0], step_q[1]};
  assign r_idx    = {step_q[2], step_q[1]};
  assign prod     = elem(a_q, a_idx) * elem(b_q, b_idx);
  assign acc_next = (step_q[0] ? acc_q : '0) + prod;

  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) && owner_q;
  assign rsp0_r     = rsp0_valid ? r_q : '0;
  assign rsp1_r     = rsp1_valid ? r_q : '0;
  assign rsp_hs     = owner_q ? rsp1_ready : rsp0_ready;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = grant ? req1_a : req0_a;
          b_d     = grant ? req1_b : req0_b;
          r_d     = '0;
          acc_d   = '0;
          step_d  = '0;
          owner_d = grant;
          last_d  = grant;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d  = acc_next;
        step_d = step_q + 3'd1;
        if (step_q[0]) begin
          r_d[(3 - int'(r_idx))*DW +: DW] = acc_next;
        end
        if (step_q == 3'd7) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mat_mul_sched.sv
// Directed bench for mat_mul_sched: inputs driven and outputs sampled on the
// falling edge, every expectation hand-computed.
module tb_mat_mul_sched;

  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req0_valid, req1_valid;
  logic [4*DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic            req0_ready, req1_ready;
  logic            rsp0_valid, rsp1_valid;
  logic [4*DW-1:0] rsp0_r, rsp1_r;
  logic            rsp0_ready, rsp1_ready;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mat_mul_sched #(.DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_r     (rsp0_r),
    .rsp0_ready (rsp0_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_r     (rsp1_r),
    .rsp1_ready (rsp1_ready),
    .busy       (busy)
  );

  // Clock and cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input logic port, input logic v, input logic [31:0] a, input logic [31:0] b);
    if (port) begin
      req1_valid = v; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    check({tag, "_rsp_valid"}, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check({tag, "_rsp0_r"}, rsp0_r, 32'd0);
    check({tag, "_rsp1_r"}, rsp1_r, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Starts in an IDLE cycle at negedge; ends in the following IDLE cycle.
  // hold = extra RESP cycles with the owner's rsp_ready low.
  task automatic run_op(input logic port, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int hold);
    drive_req(port, 1'b1, a, b);
    if (port) rsp1_ready = (hold == 0); else rsp0_ready = (hold == 0);
    #1;
    check("req_ready_granted", {31'd0, port ? req1_ready : req0_ready}, 32'd1);
    check("req_ready_other", {31'd0, port ? req0_ready : req1_ready}, 32'd0);
    @(negedge clk);
    drive_req(port, 1'b0, ~a, ~b);
    for (int c = 1; c <= 8; c++) begin
      #1;
      check("calc_busy", {31'd0, busy}, 32'd1);
      check("calc_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
      @(negedge clk);
    end
    #1;
    check("rsp_valid_port", {30'd0, rsp1_valid, rsp0_valid}, port ? 32'd2 : 32'd1);
    check("rsp_r", port ? rsp1_r : rsp0_r, exp_r);
    check("rsp_r_other", port ? rsp0_r : rsp1_r, 32'd0);
    check("rsp_busy", {31'd0, busy}, 32'd1);
    if (hold > 0) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
    end
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      #1;
      check("hold_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, port ? 32'd2 : 32'd1);
      check("hold_rsp_r", port ? rsp1_r : rsp0_r, exp_r);
      check("hold_no_req_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    if (hold > 0) begin
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (port) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    end
    @(negedge clk);
    #1;
    check("post_rsp_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int last_acc;
    logic [31:0] rr_exp;

    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    req0_a = 32'h01000001; req0_b = 32'h01020304;
    req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    last_acc = 0;

    // Reset state: ready gated even with a valid request present
    @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b0;
    #1;
    check_all_zero("after_reset");

    // Identity times B, B = [1,2;3,4]*[5,6;7,8], overflow cases, backpressure
    run_op(1'b0, 32'h01000001, 32'h01020304, 32'h01020304, 0);
    run_op(1'b1, 32'h01020304, 32'h05060708, 32'h13162B32, 0);
    run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h02020202, 0);
    run_op(1'b1, 32'h10101010, 32'h10101010, 32'h00000000, 0);
    run_op(1'b0, 32'h01020304, 32'h05060708, 32'h13162B32, 4);

    // Reset during CALC step 4
    drive_req(1'b0, 1'b1, 32'h01020304, 32'h05060708);
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check_all_zero("mid_calc_reset");
    @(negedge clk);
    #1;
    check_all_zero("mid_calc_reset_hold");
    rst_n = 1'b1;

    // Both requesters valid every cycle: grants alternate starting with req0
    drive_req(1'b0, 1'b1, 32'h01000001, 32'h01020304);
    drive_req(1'b1, 1'b1, 32'h01020304, 32'h05060708);
    #1;
    for (int op = 0; op < 4; op++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      check("rr_grant_seen", {31'd0, req0_ready | req1_ready}, 32'd1);
      check("rr_grant_port", {30'd0, req1_ready, req0_ready}, (op % 2) ? 32'd2 : 32'd1);
      if (op > 0) check("rr_accept_spacing", cyc - last_acc, 32'd10);
      last_acc = cyc;
      @(negedge clk);
      #1;
      n = 0;
      while (!(rsp0_valid || rsp1_valid) && n < 20) begin
        @(negedge clk);
        #1;
        n++;
      end
      rr_exp = (op % 2) ? 32'h13162B32 : 32'h01020304;
      check("rr_latency", cyc - last_acc, 32'd9);
      check("rr_rsp_port", {30'd0, rsp1_valid, rsp0_valid}, (op % 2) ? 32'd2 : 32'd1);
      check("rr_rsp_r", (op % 2) ? rsp1_r : rsp0_r, rr_exp);
      @(negedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
